btb_nway: RTL and testbench
===========================

# btb_nway

Parametrised N-way set-associative branch target buffer with per-entry 2-bit direction counters, tree pseudo-LRU replacement and a sequenced flush. It sits in the fetch stage. A combinational lookup port supplies hit, predicted-direction and target for the current PC. A separate update port, driven from execute, trains the entries on every resolved branch.

## Interface
- SET_COUNT, 16: number of sets; power of 2, ≥2.
- N, 4: ways per set; power of 2, ≥2.
- ADDR_WIDTH, 64: PC/target width.
- Derived: IDX_W = log2(SET_COUNT); TAG_W = ADDR_WIDTH − IDX_W − 2. Index is PC[IDX_W+1:2]; tag is PC[ADDR_WIDTH−1:IDX_W+2].

Ports:
- i_clk  in  1  clock, rising edge.
- i_arstn  in  1  reset, asynchronous, active-low.
- i_lookup_addr  in  ADDR_WIDTH  fetch PC.
- o_hit  out  1  valid tag match for i_lookup_addr.
- o_taken  out  1  o_hit & counter[1] of matching entry.
- o_target_addr  out  ADDR_WIDTH  stored target of matching entry; 0 when o_hit=0.
- i_upd_valid  in  1  resolved branch present this cycle.
- i_upd_addr  in  ADDR_WIDTH  branch PC.
- i_upd_target  in  ADDR_WIDTH  resolved target.
- i_upd_taken  in  1  resolved direction.
- i_flush  in  1  start flush (level-sampled in IDLE).
- o_busy  out  1  flush in progress.

## Operation
- Per entry: valid, tag, target, 2-bit counter (00 strong NT … 11 strong T). Per set: N−1 tree-PLRU bits.
- Lookup is purely combinational. It compares all N ways of the indexed set. If more than one way matches, the lowest-numbered way wins. Lookups never modify PLRU.
- Update, IDLE state, i_upd_valid=1:
  - Hit, taken: counter saturating +1; target ← i_upd_target; PLRU touches the way.
  - Hit, not taken: counter saturating −1; target unchanged; PLRU touches the way.
  - Miss, taken: allocate the lowest-numbered invalid way. If no way is invalid, allocate the PLRU victim. The entry is written with valid=1, the tag, the target and counter=10. PLRU touches the way.
  - Miss, not taken: no state change.
- PLRU touch: each node on the path to the way is set to point away from it. Victim: follow node bits from the root (0 = left, 1 = right).
- FSM states:
  - IDLE → FLUSH when i_flush=1; flush pointer ← 0.
  - FLUSH: each cycle, valid and PLRU bits of set[pointer] are cleared and the pointer increments. When pointer = SET_COUNT−1, the set is cleared and the FSM returns to IDLE.
- During FLUSH:
  - o_busy=1; o_hit=0; o_taken=0; o_target_addr=0.
  - i_upd_valid is ignored and dropped.
  - i_flush is ignored; there is no restart.
- Reset clears all valid bits, PLRU bits and counters (counters → 01), sets FSM to IDLE and pointer to 0. Tag and target arrays are not reset.
- Reset outputs: o_hit=0, o_taken=0, o_target_addr=0, o_busy=0.
- Reset asserted mid-flush aborts the flush. The post-reset state is identical to a normal reset.

## Timing
- Lookup: zero latency, combinational from i_lookup_addr and the array state.
- Update written at the rising edge where i_upd_valid=1. It is visible to lookups from the next cycle.
- A same-cycle lookup of the entry being updated returns the pre-update contents.
- Flush: i_flush sampled at edge k.
  - o_busy is high from after edge k until after edge k+SET_COUNT, i.e. exactly SET_COUNT cycles.
  - Updates are accepted again in the cycle after o_busy falls.
- i_flush and i_upd_valid in the same IDLE cycle: the update is performed at that edge, then the flush begins. The flush therefore erases it.
- Counter saturation boundaries: 11 + taken stays 11; 00 + not-taken stays 00.

## Test plan
- Reset, then lookup 0x1000 → o_hit=0, o_taken=0, o_target_addr=0, o_busy=0.
- Update 0x1000 taken, target 0x2000. Next cycle, lookup 0x1000 → o_hit=1, o_taken=1, target 0x2000.
- Train counter direction (same entry):
  - Two not-taken updates → o_hit=1, o_taken=0 (counter 00).
  - Third not-taken update → counter stays 00.
  - Three taken updates → counter 11.
- Replacement, N=4, SET_COUNT=16: allocate 5 taken branches mapping to set 0 (stride 0x40), with no intervening touches. The fifth evicts way 0 (the first allocated). Lookup of the first PC → miss; the other four → hit.
- Flush after 4 allocations:
  - o_busy is high exactly 16 cycles.
  - Lookups during flush → o_hit=0, even for an allocated PC.
  - An update issued during flush is not retained.
  - After flush, all lookups → miss.
- Assert i_arstn=0 at flush cycle 5 → o_busy=0 immediately. After release, i_flush starts a full 16-cycle flush.

Source files
------------

// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer.
// Combinational lookup for the fetch PC, single update port from execute,
// 2-bit direction counters per entry, tree pseudo-LRU per set, and a
// one-set-per-cycle flush sequencer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | normal operation: lookups answer, updates train entries
// S_FLUSH  | clearing valid/PLRU of set[flush_ptr]; lookups forced miss
module btb_nway #(
  parameter int SET_COUNT  = 16,
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic [ADDR_WIDTH-1:0] i_lookup_addr,
  output logic                  o_hit,
  output logic                  o_taken,
  output logic [ADDR_WIDTH-1:0] o_target_addr,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_addr,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_taken,
  input  logic                  i_flush,
  output logic                  o_busy
);

  localparam int IDX_W = $clog2(SET_COUNT);
  localparam int WAY_W = $clog2(N);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [N-1:0]            valid_q  [SET_COUNT];
  logic [TAG_W-1:0]        tag_q    [SET_COUNT][N];
  logic [ADDR_WIDTH-1:0]   target_q [SET_COUNT][N];
  logic [1:0]              ctr_q    [SET_COUNT][N];
  logic [N-2:0]            plru_q   [SET_COUNT];

  logic [0:0]              state_q;
  logic [IDX_W-1:0]        flush_ptr_q;

  // Walk from the root towards the way, pointing every node on the path away from it.
  function automatic logic [N-2:0] plru_touch(input logic [N-2:0] bits,
                                              input logic [WAY_W-1:0] way);
    logic [N-2:0]     nb;
    logic [WAY_W-1:0] node;
    logic             dir;
    nb   = bits;
    node = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir      = way[WAY_W-1-lvl];
      nb[node] = ~dir;
      node     = WAY_W'({node, dir} + (WAY_W+1)'(1));
    end
    return nb;
  endfunction

  // Follow node bits from the root (0 = left, 1 = right) to the victim way.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [N-2:0] bits);
    logic [WAY_W-1:0] v;
    logic [WAY_W-1:0] node;
    logic             dir;
    v    = '0;
    node = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir              = bits[node];
      v[WAY_W-1-lvl]   = dir;
      node             = WAY_W'({node, dir} + (WAY_W+1)'(1));
    end
    return v;
  endfunction

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             unused_addr_bits;

  assign lk_idx = i_lookup_addr[IDX_W+1:2];
  assign lk_tag = i_lookup_addr[ADDR_WIDTH-1:IDX_W+2];
  assign up_idx = i_upd_addr[IDX_W+1:2];
  assign up_tag = i_upd_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_addr_bits = ^{i_lookup_addr[1:0], i_upd_addr[1:0]};

  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;

  // Lookup tag compare; scanning downwards lets the lowest matching way win.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = N - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  assign o_busy        = (state_q == S_FLUSH);
  assign o_hit         = lk_hit && !o_busy;
  assign o_taken       = o_hit && ctr_q[lk_idx][lk_way][1];
  assign o_target_addr = o_hit ? target_q[lk_idx][lk_way] : '0;

  logic             up_hit;
  logic [WAY_W-1:0] up_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] alloc_way;
  logic [WAY_W-1:0] touch_way;
  logic [1:0]       up_ctr;
  logic [1:0]       up_ctr_next;
  logic             upd_en;

  assign upd_en = (state_q == S_IDLE) && i_upd_valid;

  // Update-side match, allocation choice and counter arithmetic.
  always_comb begin
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = N - 1; w >= 0; w--) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!valid_q[up_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    alloc_way = inv_found ? inv_way : plru_victim(plru_q[up_idx]);
    touch_way = up_hit ? up_way : alloc_way;
    up_ctr    = ctr_q[up_idx][up_way];
    if (i_upd_taken) begin
      up_ctr_next = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
    end else begin
      up_ctr_next = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
    end
  end

  // Control state: FSM, flush pointer, valid bits, counters and PLRU.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q     <= S_IDLE;
      flush_ptr_q <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < N; w++) begin
          ctr_q[s][w] <= 2'b01;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (upd_en) begin
            if (up_hit) begin
              ctr_q[up_idx][up_way] <= up_ctr_next;
              plru_q[up_idx]        <= plru_touch(plru_q[up_idx], touch_way);
            end else if (i_upd_taken) begin
              valid_q[up_idx][alloc_way] <= 1'b1;
              ctr_q[up_idx][alloc_way]   <= 2'b10;
              plru_q[up_idx]             <= plru_touch(plru_q[up_idx], touch_way);
            end
          end
          if (i_flush) begin
            state_q     <= S_FLUSH;
            flush_ptr_q <= '0;
          end
        end
        default: begin
          valid_q[flush_ptr_q] <= '0;
          plru_q[flush_ptr_q]  <= '0;
          flush_ptr_q          <= flush_ptr_q + IDX_W'(1);
          if (flush_ptr_q == IDX_W'(SET_COUNT - 1)) begin
            state_q     <= S_IDLE;
            flush_ptr_q <= '0;
          end
        end
      endcase
    end
  end

  // Tag and target storage; deliberately not reset, valid bits gate their use.
  always_ff @(posedge i_clk) begin
    if (upd_en && i_upd_taken) begin
      if (up_hit) begin
        target_q[up_idx][up_way] <= i_upd_target;
      end else begin
        tag_q[up_idx][alloc_way]    <= up_tag;
        target_q[up_idx][alloc_way] <= i_upd_target;
      end
    end
  end

endmodule

// File: tb/tb_btb_nway.sv
// Directed self-checking bench for btb_nway (SET_COUNT=16, N=4, 64-bit PCs).
module tb_btb_nway;

  logic        clk;
  logic        arstn;
  logic [63:0] lookup_addr;
  logic        hit;
  logic        taken;
  logic [63:0] target_addr;
  logic        upd_valid;
  logic [63:0] upd_addr;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic        flush;
  logic        busy;

  int n_cmp;
  int n_bad;

  btb_nway #(.SET_COUNT(16), .N(4), .ADDR_WIDTH(64)) dut (
    .i_clk         (clk),
    .i_arstn       (arstn),
    .i_lookup_addr (lookup_addr),
    .o_hit         (hit),
    .o_taken       (taken),
    .o_target_addr (target_addr),
    .i_upd_valid   (upd_valid),
    .i_upd_addr    (upd_addr),
    .i_upd_target  (upd_target),
    .i_upd_taken   (upd_taken),
    .i_flush       (flush),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    arstn     = 1'b0;
    upd_valid = 1'b0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic upd(input logic [63:0] a, input logic [63:0] t, input logic tk);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_addr   = a;
    upd_target = t;
    upd_taken  = tk;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [63:0] a);
    lookup_addr = a;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    look(64'h1000);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit got %b want 0", hit); end
    n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken got %b want 0", taken); end
    n_cmp++; if (target_addr !== 64'h0) begin n_bad++; $display("FAIL reset_target got %h want 0", target_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_alloc();
    upd(64'h1000, 64'h2000, 1'b1);
    look(64'h1000);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL alloc_hit got %b want 1", hit); end
    n_cmp++; if (taken !== 1'b1) begin n_bad++; $display("FAIL alloc_taken got %b want 1", taken); end
    n_cmp++; if (target_addr !== 64'h2000) begin n_bad++; $display("FAIL alloc_target got %h want 2000", target_addr); end
  endtask

  task automatic test_counter();
    // 10 -> 01 -> 00
    upd(64'h1000, 64'h9999, 1'b0);
    upd(64'h1000, 64'h9999, 1'b0);
    look(64'h1000);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL ctr_nt2_hit got %b want 1", hit); end
    n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL ctr_nt2_taken got %b want 0", taken); end
    n_cmp++; if (target_addr !== 64'h2000) begin n_bad++; $display("FAIL ctr_nt_target got %h want 2000", target_addr); end
    // 00 stays 00; a wrap to 11 would show taken here
    upd(64'h1000, 64'h9999, 1'b0);
    look(64'h1000);
    n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL ctr_sat_low got %b want 0", taken); end
    // 00 -> 01 still not-taken proves it sat at 00
    upd(64'h1000, 64'h2000, 1'b1);
    look(64'h1000);
    n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL ctr_01_taken got %b want 0", taken); end
    // 01 -> 10 -> 11
    upd(64'h1000, 64'h2000, 1'b1);
    upd(64'h1000, 64'h2000, 1'b1);
    look(64'h1000);
    n_cmp++; if (taken !== 1'b1) begin n_bad++; $display("FAIL ctr_11_taken got %b want 1", taken); end
    // 11 stays 11, target retrained
    upd(64'h1000, 64'h3000, 1'b1);
    look(64'h1000);
    n_cmp++; if (target_addr !== 64'h3000) begin n_bad++; $display("FAIL ctr_retarget got %h want 3000", target_addr); end
    // 11 -> 10 still taken (a wrap to 00 would give 00 here)
    upd(64'h1000, 64'h7777, 1'b0);
    look(64'h1000);
    n_cmp++; if (taken !== 1'b1) begin n_bad++; $display("FAIL ctr_sat_high got %b want 1", taken); end
    n_cmp++; if (target_addr !== 64'h3000) begin n_bad++; $display("FAIL ctr_nt_keep_target got %h want 3000", target_addr); end
    // 10 -> 01
    upd(64'h1000, 64'h7777, 1'b0);
    look(64'h1000);
    n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL ctr_10_to_01 got %b want 0", taken); end
    // not-taken miss allocates nothing
    upd(64'h1144, 64'h5555, 1'b0);
    look(64'h1144);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL nt_miss_alloc got %b want 0", hit); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    upd_valid   = 1'b1;
    upd_addr    = 64'h1104;
    upd_target  = 64'h4000;
    upd_taken   = 1'b1;
    lookup_addr = 64'h1104;
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL same_cycle_pre got %b want 0", hit); end
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL same_cycle_post_hit got %b want 1", hit); end
    n_cmp++; if (target_addr !== 64'h4000) begin n_bad++; $display("FAIL same_cycle_post_target got %h want 4000", target_addr); end
  endtask

  task automatic test_replacement();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      upd(64'(k * 64), 64'(32'hA000 + k), 1'b1);
    end
    look(64'h0);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL repl_evicted got %b want 0", hit); end
    for (int k = 1; k < 5; k++) begin
      look(64'(k * 64));
      n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL repl_kept_%0d got %b want 1", k, hit); end
      n_cmp++; if (target_addr !== 64'(32'hA000 + k)) begin n_bad++; $display("FAIL repl_target_%0d got %h want %h", k, target_addr, 32'hA000 + k); end
    end
  endtask

  task automatic test_flush();
    int cnt;
    logic [63:0] gone [6];
    gone = '{64'h40, 64'h80, 64'hC0, 64'h100, 64'h503C, 64'h1208};
    @(negedge clk);
    flush      = 1'b1;
    upd_valid  = 1'b1;
    upd_addr   = 64'h1208;
    upd_target = 64'hBEEF;
    upd_taken  = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    upd_valid = 1'b0;
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 1) begin
        lookup_addr = 64'h40;
        upd_valid   = 1'b1;
        upd_addr    = 64'h503C;
        upd_target  = 64'hCAFE;
        upd_taken   = 1'b1;
        flush       = 1'b1;
        #1;
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL flush_lookup_hit got %b want 0", hit); end
        n_cmp++; if (target_addr !== 64'h0) begin n_bad++; $display("FAIL flush_lookup_target got %h want 0", target_addr); end
      end
      @(negedge clk);
      upd_valid = 1'b0;
      flush     = 1'b0;
      #1;
    end
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL flush_busy_cycles got %0d want 16", cnt); end
    for (int k = 0; k < 6; k++) begin
      look(gone[k]);
      n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL post_flush_miss_%0d got %b want 0", k, hit); end
    end
    upd(64'h1000, 64'h6000, 1'b1);
    look(64'h1000);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL post_flush_update got %b want 1", hit); end
  endtask

  task automatic test_reset_mid_flush();
    int cnt;
    upd(64'h203C, 64'h7000, 1'b1);
    look(64'h203C);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL premid_hit got %b want 1", hit); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    arstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    look(64'h203C);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_no_resume got %b want 0", busy); end
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL midreset_cleared got %b want 0", hit); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL midreset_reflush_cycles got %0d want 16", cnt); end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    arstn       = 1'b0;
    lookup_addr = '0;
    upd_valid   = 1'b0;
    upd_addr    = '0;
    upd_target  = '0;
    upd_taken   = 1'b0;
    flush       = 1'b0;
    test_reset();
    test_alloc();
    test_counter();
    test_same_cycle();
    test_replacement();
    test_flush();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
